// File: rtl/ex_mem_skid.sv
// Execute-to-memory stage: 2-entry skid buffer (head + skid) with flush and a saturating stall counter.
// Optional macro EX_MEM_FWD_EN adds head-entry forwarding outputs (fwd_valid, fwd_rd, fwd_data).
module ex_mem_skid #(
    parameter int XLEN = 32,
    parameter int OPW  = 13,
    parameter int CNTW = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2*XLEN-1:0] in_result,
    input  logic [OPW-1:0]    in_op,
    input  logic [4:0]        in_rd,
    input  logic              in_rd_we,
    input  logic [XLEN-1:0]   in_pc,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_data,
    output logic [XLEN-1:0]   out_data_hi,
    output logic [4:0]        out_rd,
    output logic              out_rd_we,
    output logic [XLEN-1:0]   out_pc,
    output logic [CNTW-1:0]   stall_cnt
`ifdef EX_MEM_FWD_EN
    ,
    output logic              fwd_valid,
    output logic [4:0]        fwd_rd,
    output logic [XLEN-1:0]   fwd_data
`endif
);

    typedef struct packed {
        logic [XLEN-1:0] data;
        logic [XLEN-1:0] data_hi;
        logic [4:0]      rd;
        logic            rd_we;
        logic [XLEN-1:0] pc;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [OPW-1:0] OP_MUL = OPW'(1024);

    state_t state_q, state_d;
    entry_t head_q, skid_q, in_entry;

    logic accept, pop;
    logic head_load, head_from_skid, head_clr, skid_load, skid_clr;

    // The upper half is only meaningful for mul; anything else, one-hot or not, stores zero.
    always_comb begin
        in_entry         = '0;
        in_entry.data    = in_result[XLEN-1:0];
        in_entry.data_hi = (in_op == OP_MUL) ? in_result[2*XLEN-1:XLEN] : '0;
        in_entry.rd      = in_rd;
        in_entry.rd_we   = in_rd_we && (in_rd != 5'd0);
        in_entry.pc      = in_pc;
    end

    // Ready depends only on registered state, so downstream stalls never reach the ALU combinationally.
    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        head_load      = 1'b0;
        head_from_skid = 1'b0;
        head_clr       = 1'b0;
        skid_load      = 1'b0;
        skid_clr       = 1'b0;
        if (flush) begin
            state_d  = EMPTY;
            head_clr = 1'b1;
            skid_clr = 1'b1;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        head_load = 1'b1;
                        state_d   = ONE;
                    end
                end
                ONE: begin
                    if (accept && !pop) begin
                        skid_load = 1'b1;
                        state_d   = FULL;
                    end else if (accept && pop) begin
                        head_load = 1'b1;
                    end else if (pop) begin
                        head_clr = 1'b1;
                        state_d  = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        head_from_skid = 1'b1;
                        skid_clr       = 1'b1;
                        state_d        = ONE;
                    end
                end
                default: begin
                    state_d  = EMPTY;
                    head_clr = 1'b1;
                    skid_clr = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q <= '0;
        end else if (head_clr) begin
            head_q <= '0;
        end else if (head_from_skid) begin
            head_q <= skid_q;
        end else if (head_load) begin
            head_q <= in_entry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_q <= '0;
        end else if (skid_clr) begin
            skid_q <= '0;
        end else if (skid_load) begin
            skid_q <= in_entry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != {CNTW{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign out_data    = head_q.data;
    assign out_data_hi = head_q.data_hi;
    assign out_rd      = head_q.rd;
    assign out_rd_we   = head_q.rd_we;
    assign out_pc      = head_q.pc;

`ifdef EX_MEM_FWD_EN
    assign fwd_valid = out_valid && head_q.rd_we;
    assign fwd_rd    = head_q.rd;
    assign fwd_data  = head_q.data;
`endif

endmodule

// File: tb/tb_ex_mem_skid.sv
// Directed bench for ex_mem_skid: handshake, capture rules, skid/FULL, flush, saturation, async reset.
module tb_ex_mem_skid;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_result;
    logic [12:0] in_op;
    logic [4:0]  in_rd;
    logic        in_rd_we;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [31:0] out_data_hi;
    logic [4:0]  out_rd;
    logic        out_rd_we;
    logic [31:0] out_pc;
    logic [15:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    ex_mem_skid dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result), .in_op(in_op),
        .in_rd(in_rd), .in_rd_we(in_rd_we), .in_pc(in_pc), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_data_hi(out_data_hi), .out_rd(out_rd), .out_rd_we(out_rd_we),
        .out_pc(out_pc), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [63:0] res, input logic [12:0] op,
                         input logic [4:0] rd, input logic we, input logic [31:0] pc);
        in_valid  = v;
        in_result = res;
        in_op     = op;
        in_rd     = rd;
        in_rd_we  = we;
        in_pc     = pc;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        drive(1'b0, 64'd0, 13'd0, 5'd0, 1'b0, 32'd0);
        step(); step();
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        total++;
        if (stall_cnt !== 16'd0) begin bad++; $display("FAIL reset_stall got=%0h exp=0", stall_cnt); end
        total++;
        if ({out_data, out_data_hi, out_rd, out_rd_we, out_pc} !== 102'd0) begin
            bad++; $display("FAIL reset_fields got=%0h exp=0", {out_data, out_data_hi, out_rd, out_rd_we, out_pc});
        end
        total++;
        rst = 1'b0;
        step();
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        drive(1'b1, 64'h0000_0000_0000_0007, 13'd1, 5'd5, 1'b1, 32'h40);
        step();
        drive(1'b0, 64'd0, 13'd0, 5'd0, 1'b0, 32'd0);
        check("single_valid", 64'(out_valid), 64'd1);
        check("single_data", 64'(out_data), 64'd7);
        check("single_hi", 64'(out_data_hi), 64'd0);
        check("single_rd", 64'(out_rd), 64'd5);
        check("single_we", 64'(out_rd_we), 64'd1);
        check("single_pc", 64'(out_pc), 64'h40);
        step();
        check("single_drain", 64'(out_valid), 64'd0);
    endtask

    task automatic test_mul();
        out_ready = 1'b1;
        drive(1'b1, 64'h0000_0001_FFFF_FFFE, 13'd1024, 5'd7, 1'b1, 32'h50);
        step();
        check("mul_data", 64'(out_data), 64'hFFFF_FFFE);
        check("mul_hi", 64'(out_data_hi), 64'h1);
        drive(1'b1, 64'h0000_0001_FFFF_FFFE, 13'd2, 5'd7, 1'b1, 32'h54);
        step();
        check("op2_valid", 64'(out_valid), 64'd1);
        check("op2_data", 64'(out_data), 64'hFFFF_FFFE);
        check("op2_hi", 64'(out_data_hi), 64'd0);
        check("op2_pc", 64'(out_pc), 64'h54);
        drive(1'b1, 64'h0000_0001_FFFF_FFFE, 13'd1025, 5'd7, 1'b1, 32'h58);
        step();
        check("nononehot_hi", 64'(out_data_hi), 64'd0);
        drive(1'b0, 64'd0, 13'd0, 5'd0, 1'b0, 32'd0);
        step();
        check("mul_drain", 64'(out_valid), 64'd0);
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        drive(1'b1, 64'hA, 13'd1, 5'd1, 1'b1, 32'h100);
        step();
        check("b2b_a_valid", 64'(out_valid), 64'd1);
        check("b2b_a_ready", 64'(in_ready), 64'd1);
        check("b2b_a_stall", 64'(stall_cnt), 64'd0);
        drive(1'b1, 64'hB, 13'd1, 5'd2, 1'b1, 32'h104);
        step();
        drive(1'b0, 64'd0, 13'd0, 5'd0, 1'b0, 32'd0);
        check("b2b_full_ready", 64'(in_ready), 64'd0);
        check("b2b_stall1", 64'(stall_cnt), 64'd1);
        step(); step();
        check("b2b_stall3", 64'(stall_cnt), 64'd3);
        check("b2b_hold_pc", 64'(out_pc), 64'h100);
        check("b2b_hold_data", 64'(out_data), 64'hA);
        out_ready = 1'b1;
        step();
        check("b2b_b_pc", 64'(out_pc), 64'h104);
        check("b2b_b_data", 64'(out_data), 64'hB);
        check("b2b_ready_back", 64'(in_ready), 64'd1);
        check("b2b_stall_kept", 64'(stall_cnt), 64'd3);
        step();
        check("b2b_drain", 64'(out_valid), 64'd0);
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(1'b1, 64'hC, 13'd1, 5'd3, 1'b1, 32'h110);
        step();
        drive(1'b1, 64'hD, 13'd1, 5'd4, 1'b1, 32'h114);
        step();
        check("flush_full", 64'(in_ready), 64'd0);
        drive(1'b1, 64'hE, 13'd1, 5'd6, 1'b1, 32'h200);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 64'd0, 13'd0, 5'd0, 1'b0, 32'd0);
        check("flush_valid", 64'(out_valid), 64'd0);
        check("flush_ready", 64'(in_ready), 64'd1);
        check("flush_stall_kept", 64'(stall_cnt), 64'd5);
        out_ready = 1'b1;
        step();
        check("flush_no_e", 64'(out_valid), 64'd0);
    endtask

    task automatic test_rd_zero_and_saturate();
        out_ready = 1'b1;
        drive(1'b1, 64'h99, 13'd1, 5'd0, 1'b1, 32'h300);
        step();
        drive(1'b0, 64'd0, 13'd0, 5'd0, 1'b0, 32'd0);
        out_ready = 1'b0;
        check("rd0_valid", 64'(out_valid), 64'd1);
        check("rd0_we", 64'(out_rd_we), 64'd0);
        for (int i = 0; i < 70000; i++) step();
        check("sat_stall", 64'(stall_cnt), 64'hFFFF);
        check("sat_hold_pc", 64'(out_pc), 64'h300);
    endtask

    task automatic test_async_reset();
        drive(1'b1, 64'hF, 13'd1, 5'd9, 1'b1, 32'h400);
        step();
        drive(1'b0, 64'd0, 13'd0, 5'd0, 1'b0, 32'd0);
        check("arst_pre_full", 64'(in_ready), 64'd0);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", 64'(out_valid), 64'd0);
        check("arst_stall", 64'(stall_cnt), 64'd0);
        check("arst_ready", 64'(in_ready), 64'd1);
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        step();
        check("arst_empty_after", 64'(out_valid), 64'd0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_mul();
        test_back_to_back();
        test_flush();
        test_rd_zero_and_saturate();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
